fx_match_arbiter: RTL and testbench

- Shares one fixed-point requantization datapath (right-shift, round, saturate) among NREQ requesters.
- Each requester supplies its own signed sample and a per-request LSB-drop shift amount.
- A round-robin arbiter grants one requester per cycle. The result leaves through a 2-stage valid/ready pipeline, tagged with the requester id.
- Sits between multiple M2V datapath lanes and a single downstream consumer, replacing per-lane format-match instances.

---
 rtl/fx_match_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fx_match_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_match_arbiter.sv
// Round-robin shared requantizer: NREQ requesters feed one shift/round/saturate datapath
// behind a 2-stage valid/ready pipeline. Define FXM_SAT_FLAG_EN to add o_sat and sat_cnt.
module fx_match_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 13,
    parameter int OW   = 10,
    parameter int SHW  = 4,
    parameter int RND  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*IW-1:0]        req_data,
    input  logic [NREQ*SHW-1:0]       req_shift,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [OW-1:0]             o_data,
    output logic [$clog2(NREQ)-1:0]   o_id,
    output logic                      busy
`ifdef FXM_SAT_FLAG_EN
    ,
    output logic                      o_sat,
    output logic [15:0]               sat_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam logic signed [IW:0] SAT_MAX = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] SAT_MIN = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [OW-1:0]      OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]      OUT_MIN = {1'b1, {(OW-1){1'b0}}};

    logic                 s1_valid_q;
    logic [IW-1:0]        s1_data_q;
    logic [SHW-1:0]       s1_shift_q;
    logic [IDW-1:0]       s1_id_q;
    logic                 o_valid_q;
    logic [OW-1:0]        o_data_q;
    logic [IDW-1:0]       o_id_q;
    logic [IDW-1:0]       ptr_q;

    logic [IW-1:0]        s1_data_d;
    logic [SHW-1:0]       s1_shift_d;
    logic [OW-1:0]        o_data_d;
    logic [IDW-1:0]       ptr_d;

    logic                 s2Adv;
    logic                 s1Accept;
    logic                 grantValid;
    logic                 take;
    logic [NREQ-1:0]      reqRot;
    logic [IDW-1:0]       grantOff;
    logic [IDW-1:0]       grantIdx;
    logic [IDW:0]         grantSum;
    logic [IDW:0]         nextSum;
    int                   effShift;
    logic signed [IW:0]   widened;
    logic signed [IW:0]   shifted;

`ifdef FXM_SAT_FLAG_EN
    logic                 o_sat_q;
    logic                 o_sat_d;
    logic [15:0]          sat_cnt_q;
`endif

    assign s2Adv    = !o_valid_q || o_ready;
    assign s1Accept = !s1_valid_q || s2Adv;
    // Reset also blocks the handshake so no requester sees a phantom accept.
    assign take     = grantValid && s1Accept && rst_n;

    always_comb begin
        reqRot     = NREQ'({req_valid, req_valid} >> ptr_q);
        grantValid = |reqRot;
        grantOff   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (reqRot[j]) begin
                grantOff = IDW'(j);
            end
        end
        grantSum = {1'b0, ptr_q} + {1'b0, grantOff};
        if (grantSum >= (IDW+1)'(NREQ)) begin
            grantSum = grantSum - (IDW+1)'(NREQ);
        end
        grantIdx = grantSum[IDW-1:0];
        nextSum  = {1'b0, grantIdx} + (IDW+1)'(1);
        ptr_d    = (nextSum == (IDW+1)'(NREQ)) ? '0 : nextSum[IDW-1:0];
    end

    always_comb begin
        req_ready  = '0;
        s1_data_d  = '0;
        s1_shift_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                req_ready[i] = take;
                s1_data_d    = req_data[i*IW +: IW];
                s1_shift_d   = req_shift[i*SHW +: SHW];
            end
        end
    end

    // Shift clamps at IW-1 so oversized shift fields never wrap.
    always_comb begin
        effShift = (int'(s1_shift_q) > IW - 1) ? IW - 1 : int'(s1_shift_q);
        widened  = {s1_data_q[IW-1], s1_data_q};
        if (RND != 0 && effShift > 0) begin
            widened = widened + ((IW+1)'(1) << (effShift - 1));
        end
        shifted = widened >>> effShift;
        if (shifted > SAT_MAX) begin
            o_data_d = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            o_data_d = OUT_MIN;
        end else begin
            o_data_d = shifted[OW-1:0];
        end
`ifdef FXM_SAT_FLAG_EN
        o_sat_d = (shifted > SAT_MAX) || (shifted < SAT_MIN);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s1_id_q    <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_id_q     <= '0;
            ptr_q      <= '0;
`ifdef FXM_SAT_FLAG_EN
            o_sat_q    <= 1'b0;
            sat_cnt_q  <= '0;
`endif
        end else begin
            if (take) begin
                ptr_q <= ptr_d;
            end
            if (s1Accept) begin
                s1_valid_q <= take;
                if (take) begin
                    s1_data_q  <= s1_data_d;
                    s1_shift_q <= s1_shift_d;
                    s1_id_q    <= grantIdx;
                end
            end
            if (s2Adv) begin
                o_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    o_data_q <= o_data_d;
                    o_id_q   <= s1_id_q;
`ifdef FXM_SAT_FLAG_EN
                    o_sat_q  <= o_sat_d;
`endif
                end
            end
`ifdef FXM_SAT_FLAG_EN
            if (o_valid_q && o_ready && o_sat_q && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_q <= sat_cnt_q + 16'd1;
            end
`endif
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_id    = o_id_q;
    assign busy    = s1_valid_q || o_valid_q;
`ifdef FXM_SAT_FLAG_EN
    assign o_sat   = o_sat_q;
    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fx_match_arbiter.sv
// Bench for fx_match_arbiter: one rounding and one truncating instance share stimulus and
// are checked every cycle against a queue-based model. Honours FXM_SAT_FLAG_EN when defined.
module tb_fx_match_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [51:0] req_data = '0;
    logic [15:0] req_shift = '0;
    logic        o_ready = 1'b0;
    logic [3:0]  rdy1, rdy0;
    logic        ov1, ov0, busy1, busy0;
    logic [9:0]  od1, od0;
    logic [1:0]  oid1, oid0;
`ifdef FXM_SAT_FLAG_EN
    logic        sat1, sat0;
    logic [15:0] cnt1, cnt0;
`endif

    always #5 clk = ~clk;

    fx_match_arbiter #(.RND(1)) dutRnd (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .req_data(req_data), .req_shift(req_shift), .o_valid(ov1), .o_ready(o_ready),
        .o_data(od1), .o_id(oid1), .busy(busy1)
`ifdef FXM_SAT_FLAG_EN
        , .o_sat(sat1), .sat_cnt(cnt1)
`endif
    );

    fx_match_arbiter #(.RND(0)) dutTrunc (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
        .req_data(req_data), .req_shift(req_shift), .o_valid(ov0), .o_ready(o_ready),
        .o_data(od0), .o_id(oid0), .busy(busy0)
`ifdef FXM_SAT_FLAG_EN
        , .o_sat(sat0), .sat_cnt(cnt0)
`endif
    );

    typedef struct { int d; int sh; } req_t;
    typedef struct { int id; int r1; int r0; bit s1; bit s0; int acc; } exp_t;

    req_t pend[4][$];
    exp_t expQ[$];
    int   idLog[$];
    int   mptr = 0, cyc = 0, errors = 0, checks = 0;
    int   satCnt1 = 0, satCnt0 = 0;
    int   lastId = 0, lastR1 = 0, lastR0 = 0;
    int   dutAccepts = 0, delivered = 0;

    // Reference arithmetic via real-valued floor division, independent of bit tricks.
    function automatic int requant(int d, int sh, int rnd, output bit sat);
        int  s;
        int  v;
        real q;
        s = (sh > 12) ? 12 : sh;
        if (rnd != 0 && s > 0) q = $floor((real'(d) + real'(2 ** (s - 1))) / real'(2 ** s));
        else                   q = $floor(real'(d) / real'(2 ** s));
        v = $rtoi(q);
        sat = 1'b0;
        if (v > 511)  begin v = 511;  sat = 1'b1; end
        if (v < -512) begin v = -512; sat = 1'b1; end
        return v;
    endfunction

    function automatic bit anyPend();
        bit a = 1'b0;
        for (int i = 0; i < 4; i++) if (pend[i].size() > 0) a = 1'b1;
        return a;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic pushReq(int id, int d, int sh);
        req_t r;
        r.d = d;
        r.sh = sh;
        pend[id].push_back(r);
    endtask

    task automatic checkOutput();
        bit ev;
        ev = rst_n && expQ.size() > 0 && cyc >= expQ[0].acc + 1;
        check("o_valid_rnd", int'(ov1), int'(ev));
        check("o_valid_trunc", int'(ov0), int'(ev));
        check("busy_rnd", int'(busy1), int'(rst_n && expQ.size() > 0));
        check("busy_trunc", int'(busy0), int'(rst_n && expQ.size() > 0));
        if (ev) begin
            check("o_data_rnd", int'($signed(od1)), expQ[0].r1);
            check("o_data_trunc", int'($signed(od0)), expQ[0].r0);
            check("o_id_rnd", int'(oid1), expQ[0].id);
            check("o_id_trunc", int'(oid0), expQ[0].id);
`ifdef FXM_SAT_FLAG_EN
            check("o_sat_rnd", int'(sat1), int'(expQ[0].s1));
            check("o_sat_trunc", int'(sat0), int'(expQ[0].s0));
`endif
        end
`ifdef FXM_SAT_FLAG_EN
        check("sat_cnt_rnd", int'(cnt1), satCnt1);
        check("sat_cnt_trunc", int'(cnt0), satCnt0);
`endif
    endtask

    // One cycle: check registered outputs, drive inputs, then predict this edge's transfers.
    task automatic applyStimulus(bit rdy);
        int   g;
        bit   ev;
        req_t r;
        exp_t e;
        @(negedge clk);
        checkOutput();
        o_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*13 +: 13] = 13'(pend[i][0].d);
                req_shift[i*4 +: 4]  = 4'(pend[i][0].sh);
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        g = -1;
        if (rst_n && (expQ.size() < 2 || rdy)) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && pend[(mptr + k) % 4].size() > 0) g = (mptr + k) % 4;
            end
        end
        check("req_ready_rnd", int'(rdy1), (g >= 0) ? (1 << g) : 0);
        check("req_ready_trunc", int'(rdy0), (g >= 0) ? (1 << g) : 0);
        if ((rdy1 & req_valid) != 4'd0) dutAccepts++;
        if (ov1 && rdy) begin
            lastId = int'(oid1);
            lastR1 = int'($signed(od1));
            lastR0 = int'($signed(od0));
            idLog.push_back(int'(oid1));
            delivered++;
        end
        ev = rst_n && expQ.size() > 0 && cyc >= expQ[0].acc + 1;
        if (ev && rdy) begin
            if (expQ[0].s1 && satCnt1 < 65535) satCnt1++;
            if (expQ[0].s0 && satCnt0 < 65535) satCnt0++;
            void'(expQ.pop_front());
        end
        if (g >= 0) begin
            r = pend[g].pop_front();
            e.id  = g;
            e.r1  = requant(r.d, r.sh, 1, e.s1);
            e.r0  = requant(r.d, r.sh, 0, e.s0);
            e.acc = cyc + 1;
            expQ.push_back(e);
            mptr = (g + 1) % 4;
        end
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((anyPend() || expQ.size() > 0) && n < 200) begin
            applyStimulus(1'b1);
            n++;
        end
        check("drain_done", int'(n < 200), 1);
    endtask

    task automatic runSingle(int id, int d, int sh, int lit1, int lit0);
        pushReq(id, d, sh);
        drain();
        check("lit_rnd", lastR1, lit1);
        check("lit_trunc", lastR0, lit0);
        check("lit_id", lastId, id);
    endtask

    initial begin
        int rrExp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int a0, d0;

        repeat (2) @(posedge clk);
        #2;
        check("reset_o_valid", int'(ov1), 0);
        check("reset_o_data", int'(od1), 0);
        check("reset_o_id", int'(oid1), 0);
        check("reset_busy", int'(busy1), 0);
        check("reset_req_ready", int'(rdy1), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            pushReq(i, 10 * i + 1, 0);
            pushReq(i, -20 * i - 3, 1);
        end
        idLog.delete();
        drain();
        check("rr_count", idLog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < idLog.size()) check("rr_order", idLog[i], rrExp[i]);
        end

        runSingle(0, 4095, 0, 511, 511);
        runSingle(1, 100, 3, 13, 12);
        runSingle(2, -100, 3, -12, -13);
        runSingle(3, -4096, 15, -1, -1);
        runSingle(0, -4096, 0, -512, -512);
        runSingle(1, 1023, 1, 511, 511);
        runSingle(2, -1, 4, 0, -1);
        runSingle(3, 4095, 12, 1, 0);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) pushReq(i, 300 * i - 97 * j, i + j);
        end
        d0 = delivered;
        repeat (4) applyStimulus(1'b1);
        a0 = dutAccepts;
        repeat (5) applyStimulus(1'b0);
        check("stall_accepts_le2", int'(dutAccepts - a0 <= 2), 1);
        check("stall_ready_zero", int'(rdy1), 0);
        drain();
        check("stall_delivered", delivered - d0, 16);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) pushReq(i, 50 * j - 7 * i, 2);
        end
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_o_valid", int'(ov1), 0);
        check("midreset_busy", int'(busy1), 0);
        expQ.delete();
        mptr = 0;
        satCnt1 = 0;
        satCnt0 = 0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idLog.delete();
        drain();
        check("first_after_reset", (idLog.size() > 0) ? idLog[0] : -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
